// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: data width and the memory-port arbiter states.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        D_BUSY,
        D_DONE,
        I_BUSY,
        I_DONE
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the
// memory stage, with data priority, a fetch slot after every data access, and stall generation.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            InstrReqF,
    input  logic [XLEN-1:0] PCF,
    input  logic            RedirectF,
    output logic [XLEN-1:0] InstrF,
    output logic            InstrValidF,
    output logic            StallF,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            DataValidM,
    output logic            StallM,
    output logic            MemReq,
    output logic            MemWe,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWData,
    input  logic [XLEN-1:0] MemRData,
    input  logic            MemReady,
    output logic            MemTimeout
);

    arb_state_t  state;
    logic        stale;
    logic [15:0] wait_cnt;
    logic [16:0] wait_next;
    logic        data_req;
    logic        busy;
    logic        grant_data;
    logic        grant_instr;

    assign data_req  = MemReadM | MemWriteM;
    assign busy      = (state == D_BUSY) || (state == I_BUSY);
    assign wait_next = {1'b0, wait_cnt} + 17'd1;

    // A data grant is possible from IDLE or right after a fetch; a fetch grant
    // from IDLE (when no data is waiting) or right after a data access.
    assign grant_data  = ((state == IDLE) || (state == I_DONE)) && data_req;
    assign grant_instr = ((state == IDLE) && !data_req && InstrReqF) ||
                         ((state == D_DONE) && InstrReqF);

    assign MemReq      = busy;
    assign DataValidM  = (state == D_DONE);
    assign InstrValidF = (state == I_DONE);
    assign StallM      = data_req & ~DataValidM;
    assign StallF      = InstrReqF & ~InstrValidF;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            MemWe      <= 1'b0;
            MemAddr    <= '0;
            MemWData   <= '0;
            InstrF     <= '0;
            ReadDataM  <= '0;
            MemTimeout <= 1'b0;
            stale      <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (grant_data) begin
                MemAddr  <= ALUResultM;
                MemWe    <= MemWriteM;
                MemWData <= WriteDataM;
            end else if (grant_instr) begin
                MemAddr <= PCF;
                MemWe   <= 1'b0;
            end

            if (grant_data || grant_instr) begin
                wait_cnt <= '0;
            end else if (busy && !MemReady && (wait_cnt != 16'hFFFF)) begin
                wait_cnt <= wait_next[15:0];
            end

            // The flag is sticky; the access itself keeps waiting for memory.
            if (busy && !MemReady && (wait_next >= 17'(TIMEOUT))) begin
                MemTimeout <= 1'b1;
            end

            if (grant_instr) begin
                stale <= 1'b0;
            end else if ((state == I_BUSY) && (RedirectF || !InstrReqF)) begin
                stale <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state <= D_BUSY;
                    end else if (grant_instr) begin
                        state <= I_BUSY;
                    end
                end
                D_BUSY: begin
                    if (MemReady) begin
                        state <= D_DONE;
                        if (!MemWe) begin
                            ReadDataM <= MemRData;
                        end
                    end
                end
                D_DONE: begin
                    state <= InstrReqF ? I_BUSY : IDLE;
                end
                I_BUSY: begin
                    if (MemReady) begin
                        InstrF <= MemRData;
                        state  <= (stale || RedirectF || !InstrReqF) ? IDLE : I_DONE;
                    end
                end
                I_DONE: begin
                    state <= data_req ? D_BUSY : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores driven by EX/MEM register outputs). Sequences each access with a request/ready handshake, holds the returned word, and produces the stall signals that freeze the fetch stage and the EX/MEM register (and, through the hazard unit, every earlier stage) until the stage's access has completed. Data accesses take priority. A pending fetch is always served next after a data access, so fetch cannot starve.

## Interface
Parameters:
- TIMEOUT, 255: number of wait cycles without MemReady before MemTimeout is raised. The range is 1..65535.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- InstrReqF  in  1  fetch stage wants the word at PCF.
- PCF  in  32  fetch address.
- RedirectF  in  1  one-cycle pulse on a branch/jump redirect; marks any in-flight fetch as stale.
- InstrF  out  32  fetched instruction. Valid only when InstrValidF=1.
- InstrValidF  out  1  InstrF is valid this cycle.
- StallF  out  1  freezes PC and IF/ID.
- MemReadM  in  1  memory-stage load.
- MemWriteM  in  1  memory-stage store.
- ALUResultM  in  32  load/store address.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load result. Valid only when DataValidM=1.
- DataValidM  out  1  memory-stage access has completed this cycle.
- StallM  out  1  freezes EX/MEM and all earlier stages.
- MemReq  out  1  request to memory.
- MemWe  out  1  write enable; meaningful only while MemReq=1.
- MemAddr  out  32  registered address.
- MemWData  out  32  registered write data.
- MemRData  in  32  read data; sampled in the cycle MemReady=1.
- MemReady  in  1  memory completes the current request this cycle.
- MemTimeout  out  1  sticky error flag.

## Operation
- The FSM has five states: IDLE, D_BUSY, D_DONE, I_BUSY, I_DONE.
- Transitions out of IDLE:
  - If MemReadM|MemWriteM, go to D_BUSY.
  - Otherwise, if InstrReqF, go to I_BUSY.
  - Otherwise stay in IDLE.
- On any entry to a BUSY state:
  - Latch MemAddr, MemWe and MemWData from the granted side. For fetch, MemWe=0 and MemWData is unchanged.
  - Clear the wait counter.
  - On entry to I_BUSY, also clear the stale flag.
- MemReq=1 exactly while the FSM is in D_BUSY or I_BUSY. MemAddr, MemWe and MemWData stay stable until the cycle in which MemReady=1.
- D_BUSY with MemReady=1:
  - Go to D_DONE.
  - Capture MemRData into the ReadDataM register. Capture on loads only; on a store, ReadDataM holds its previous value.
- I_BUSY with MemReady=1:
  - Capture MemRData into the InstrF register.
  - Go to I_DONE, unless the stale flag is set or RedirectF=1 this cycle. In that case go to IDLE and discard the data.
- D_DONE: go to I_BUSY if InstrReqF=1, otherwise go to IDLE. The data request is not re-sampled in D_DONE, because it belongs to the instruction that is retiring.
- I_DONE: go to D_BUSY if MemReadM|MemWriteM, otherwise go to IDLE. The fetch request is not re-sampled in I_DONE, because the PC advances at the end of this cycle.
- The stale flag is set by RedirectF while the FSM is in I_BUSY.
- If InstrReqF drops during I_BUSY, the transaction still completes (memory cannot abort) and the data is discarded, as for a stale fetch.
- Combinational outputs:
  - DataValidM = (state==D_DONE).
  - InstrValidF = (state==I_DONE).
  - StallM = (MemReadM|MemWriteM) & ~DataValidM.
  - StallF = InstrReqF & ~InstrValidF.
- Wait counter:
  - 16-bit, increments each BUSY cycle in which MemReady=0, and saturates.
  - When it reaches TIMEOUT, MemTimeout is set. MemTimeout stays set until reset.
  - A timeout does not abandon the transaction; the FSM keeps waiting.

## Timing
- Reset values: state IDLE, MemReq 0, MemWe 0, MemAddr 0, MemWData 0, InstrF 0, ReadDataM 0, InstrValidF 0, DataValidM 0, MemTimeout 0, stale flag 0, counter 0.
- An assertion of RST_N low mid-transaction drops MemReq immediately.
- Minimum access latency is 3 cycles from request to result:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: BUSY, with MemReady=1.
  - Cycle 2: DONE, with the Valid output asserted and the stall released.
- Each memory wait cycle adds one cycle.
- Simultaneous fetch and data requests in IDLE:
  - The data access goes first.
  - The fetch follows immediately from D_DONE, with no IDLE bubble.
- Back-to-back fetches with no data traffic take 3 cycles each: IDLE → I_BUSY → I_DONE → IDLE.

## Structure
- The shared package riscv_pkg holds the arbiter state enum (IDLE, D_BUSY, D_DONE, I_BUSY, I_DONE) and the XLEN=32 constant.
- A single module implements the block. The timeout counter stays inline; no sub-module is warranted.

## Test plan
- Single load: MemReadM=1, ALUResultM=0x100, MemReady asserted on the first BUSY cycle with MemRData=0xDEADBEEF → MemReq high for 1 cycle with MemAddr=0x100, MemWe=0; ReadDataM=0xDEADBEEF and DataValidM=1 in the next cycle; StallM high for exactly 2 cycles.
- Store with 3 wait states: MemWriteM=1, address 0x200, WriteDataM=0x12345678 → MemReq, MemWe, MemAddr and MemWData held stable for 4 cycles; StallM high for 5 cycles; ReadDataM unchanged.
- Contention: InstrReqF=1 (PCF=0x40) and MemReadM=1 raised in the same cycle → data transaction first, then I_BUSY entered directly from D_DONE; InstrValidF=1 with InstrF equal to the memory word at 0x40.
- Redirect: RedirectF pulsed during I_BUSY, MemReady arrives 2 cycles later → no InstrValidF pulse; FSM returns to IDLE; the next fetch uses the new PCF.
- Timeout: TIMEOUT=4, MemReady held low → MemTimeout rises after 4 wait cycles and stays high; a later MemReady still completes the access normally.
- Reset mid-access: RST_N driven low during D_BUSY → MemReq=0 and all outputs at their reset values asynchronously; after release, the FSM restarts from IDLE.
